// File: rtl/comp_link_pkg.sv
// Shared constants for the comparator optical link.
// Holds the transmit state encoding, the K28.5 comma character, the default
// idle/fill word, the frame length and the word-index constants of a frame.
package comp_link_pkg;

  // Transmit state encoding; the values are visible on the STATE port.
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // K28.5 comma used as the low byte of every frame header.
  localparam logic [7:0] K28_5 = 8'hBC;

  // Default fill word: K28.5 in the low byte, D16.2 in the high byte.
  localparam logic [15:0] LINK_IDLE_WORD = 16'h50BC;

  // A frame is four 16-bit words, W0 (header) to W3.
  localparam int FRAME_LEN = 4;

  localparam logic [1:0] W0 = 2'd0;
  localparam logic [1:0] W1 = 2'd1;
  localparam logic [1:0] W2 = 2'd2;
  localparam logic [1:0] W3 = 2'(FRAME_LEN - 1);

  // Per-byte K flags: header and idle words carry a comma in the low byte.
  localparam logic [1:0] TXK_CTRL = 2'b01;
  localparam logic [1:0] TXK_DATA = 2'b00;

endpackage

// File: rtl/comp_frame_mux.sv
// Combinational word selector for the comparator link frame.
// Ports:
//   phase  in  2   word index of the word being selected (W0..W3)
//   state  in  2   transmit state the word belongs to
//   idle   in  1   the frame is an idle/fill frame
//   seq    in  8   sequence number placed in the W0 header
//   hold   in  48  captured comparator bits {G6C,G5C,G4C,G3C,G2C,G1C}
//   txd    out 16  selected transmit word
//   txk    out 2   per-byte K flags for txd
// The parent registers txd/txk, so this block has no clock.
module comp_frame_mux
  import comp_link_pkg::*;
#(
  parameter logic [15:0] IDLE_WORD = LINK_IDLE_WORD
) (
  input  logic [1:0]  phase,
  input  logic [1:0]  state,
  input  logic        idle,
  input  logic [7:0]  seq,
  input  logic [47:0] hold,
  output logic [15:0] txd,
  output logic [1:0]  txk
);

  // Anything other than a data frame in RUN collapses to the fill word, so a
  // stale idle flag outside RUN can never leak comparator bits onto the link.
  always_comb begin
    txd = IDLE_WORD;
    txk = TXK_CTRL;
    if (state == ST_RUN && !idle) begin
      case (phase)
        W0: begin
          txd = {seq, K28_5};
          txk = TXK_CTRL;
        end
        W1: begin
          txd = hold[15:0];
          txk = TXK_DATA;
        end
        W2: begin
          txd = hold[31:16];
          txk = TXK_DATA;
        end
        default: begin
          txd = hold[47:32];
          txk = TXK_DATA;
        end
      endcase
    end
  end

endmodule

// File: rtl/comp_frame_tx.sv
// Transmit framer for the comparator path to the trigger motherboard.
// Packs one bunch crossing of the six 8-bit layer comparator buses into a
// four-word frame (header with sequence number, then three data words),
// sends idle fill while the link is off or synchronising, optionally
// suppresses all-zero crossings, and flags bunch strobes that arrive out of
// frame phase.
// Ports:
//   CLK          in  1   transmit clock (4x LCT clock)
//   RST_B        in  1   asynchronous active-low reset
//   G1C..G6C     in  8   layer comparator bits, synchronous to CLK
//   BX_STRB      in  1   bunch-crossing start strobe
//   EN           in  1   enable data transmission
//   ZS_EN        in  1   zero-suppression enable, sampled at frame start
//   LINK_RDY     in  1   transmitter ready; low forces OFF at once
//   TXD          out 16  registered transmit word
//   TXK          out 2   registered per-byte K flags
//   STATE        out 2   0=OFF, 1=SYNC, 2=RUN
//   ALIGN_ERR    out 1   pulse when BX_STRB arrives mid-frame
//   DATA_FRAMES  out 16  saturating count of data frames sent
module comp_frame_tx
  import comp_link_pkg::*;
#(
  parameter int unsigned SYNC_FRAMES = 16,
  parameter logic [15:0] IDLE_WORD   = LINK_IDLE_WORD,
  parameter bit          ZS_DEFAULT  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic [7:0]  G1C,
  input  logic [7:0]  G2C,
  input  logic [7:0]  G3C,
  input  logic [7:0]  G4C,
  input  logic [7:0]  G5C,
  input  logic [7:0]  G6C,
  input  logic        BX_STRB,
  input  logic        EN,
  input  logic        ZS_EN,
  input  logic        LINK_RDY,
  output logic [15:0] TXD,
  output logic [1:0]  TXK,
  output logic [1:0]  STATE,
  output logic        ALIGN_ERR,
  output logic [15:0] DATA_FRAMES
);

  localparam logic [8:0] SYNC_LIMIT = 9'(SYNC_FRAMES);

  logic [1:0]  phase, phase_d;
  logic [1:0]  state, state_d;
  logic [7:0]  sync_cnt, sync_d;
  logic [7:0]  seq, seq_d;
  logic [15:0] data_frames, data_frames_d;
  logic [47:0] hold, hold_d;
  logic        frame_idle, idle_d;
  logic        zs_flag, zs_d;
  logic        align_d;
  logic        frame_start;
  logic [47:0] bus_in;
  logic [15:0] txd_d;
  logic [1:0]  txk_d;

  assign bus_in      = {G6C, G5C, G4C, G3C, G2C, G1C};
  assign frame_start = BX_STRB || (phase == W3);

  // Next-state logic. The output word is selected from the *next* phase and
  // frame contents so that the header appears one clock after frame start.
  // A frame that ends at W3 as data advances SEQ; a frame cut short by an
  // early strobe or by a link drop never reaches W3 and leaves SEQ alone.
  always_comb begin
    phase_d       = frame_start ? W0 : phase + 2'd1;
    hold_d        = frame_start ? bus_in : hold;
    zs_d          = frame_start ? ZS_EN : zs_flag;
    align_d       = BX_STRB && (phase != W3);
    state_d       = state;
    sync_d        = sync_cnt;
    seq_d         = seq;
    idle_d        = frame_idle;
    data_frames_d = data_frames;

    if (!LINK_RDY) begin
      state_d = ST_OFF;
      sync_d  = 8'd0;
      idle_d  = 1'b1;
    end else begin
      if (phase == W3 && state == ST_RUN && !frame_idle) begin
        seq_d = seq + 8'd1;
      end
      if (frame_start) begin
        case (state)
          ST_OFF: begin
            if (EN) begin
              state_d = ST_SYNC;
              sync_d  = 8'd0;
            end
          end
          ST_SYNC: begin
            if (!EN) begin
              state_d = ST_OFF;
              sync_d  = 8'd0;
            end else if (({1'b0, sync_cnt} + 9'd1) >= SYNC_LIMIT) begin
              state_d = ST_RUN;
              seq_d   = 8'd0;
            end else begin
              sync_d = sync_cnt + 8'd1;
            end
          end
          ST_RUN: begin
            if (!EN) begin
              state_d = ST_OFF;
            end
          end
          default: begin
            state_d = ST_OFF;
            sync_d  = 8'd0;
          end
        endcase
        idle_d = !((state_d == ST_RUN) && !(zs_d && (bus_in == 48'd0)));
        if (!idle_d && data_frames != 16'hFFFF) begin
          data_frames_d = data_frames + 16'd1;
        end
      end
    end
  end

  comp_frame_mux #(
    .IDLE_WORD(IDLE_WORD)
  ) u_mux (
    .phase(phase_d),
    .state(state_d),
    .idle (idle_d),
    .seq  (seq_d),
    .hold (hold_d),
    .txd  (txd_d),
    .txk  (txk_d)
  );

  // All state, counters and the output word. Reset parks the phase at W3 so
  // the very first clock after reset is a frame start.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      phase       <= W3;
      state       <= ST_OFF;
      sync_cnt    <= 8'd0;
      seq         <= 8'd0;
      data_frames <= 16'd0;
      hold        <= 48'd0;
      frame_idle  <= 1'b1;
      zs_flag     <= ZS_DEFAULT;
      ALIGN_ERR   <= 1'b0;
      TXD         <= IDLE_WORD;
      TXK         <= TXK_CTRL;
    end else begin
      phase       <= phase_d;
      state       <= state_d;
      sync_cnt    <= sync_d;
      seq         <= seq_d;
      data_frames <= data_frames_d;
      hold        <= hold_d;
      frame_idle  <= idle_d;
      zs_flag     <= zs_d;
      ALIGN_ERR   <= align_d;
      TXD         <= txd_d;
      TXK         <= txk_d;
    end
  end

  assign STATE       = state;
  assign DATA_FRAMES = data_frames;

endmodule

// File: tb/tb_comp_frame_tx.sv
// Self-checking bench for comp_frame_tx: expected words are queued when a
// frame is driven and popped one per clock as the DUT emits them.
module tb_comp_frame_tx;

  logic        CLK = 1'b0;
  logic        RST_B;
  logic [7:0]  G1C, G2C, G3C, G4C, G5C, G6C;
  logic        BX_STRB, EN, ZS_EN, LINK_RDY;
  logic [15:0] TXD;
  logic [1:0]  TXK;
  logic [1:0]  STATE;
  logic        ALIGN_ERR;
  logic [15:0] DATA_FRAMES;

  comp_frame_tx #(
    .SYNC_FRAMES(16),
    .IDLE_WORD  (16'h50BC),
    .ZS_DEFAULT (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST_B      (RST_B),
    .G1C        (G1C),
    .G2C        (G2C),
    .G3C        (G3C),
    .G4C        (G4C),
    .G5C        (G5C),
    .G6C        (G6C),
    .BX_STRB    (BX_STRB),
    .EN         (EN),
    .ZS_EN      (ZS_EN),
    .LINK_RDY   (LINK_RDY),
    .TXD        (TXD),
    .TXK        (TXK),
    .STATE      (STATE),
    .ALIGN_ERR  (ALIGN_ERR),
    .DATA_FRAMES(DATA_FRAMES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] txd;
    logic [1:0]  txk;
    logic [1:0]  state;
    logic        align;
  } exp_t;

  typedef struct {
    logic [47:0] g;
    logic        zs;
    logic        data;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          compared   = 0;
  int          mismatched = 0;
  int          exp_frames = 0;
  logic [7:0]  exp_seq    = 8'd0;
  string       tag        = "init";
  logic [47:0] gbus;

  function automatic logic [47:0] rand_bus();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  task automatic drive_bus(input logic [47:0] g);
    {G6C, G5C, G4C, G3C, G2C, G1C} = g;
  endtask

  task automatic push_word(input logic [15:0] txd, input logic [1:0] txk,
                           input logic [1:0] st, input logic al);
    exp_t e;
    e.txd   = txd;
    e.txk   = txk;
    e.state = st;
    e.align = al;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic [1:0] st);
    for (int i = 0; i < 4; i++) push_word(16'h50BC, 2'b01, st, 1'b0);
  endtask

  task automatic push_data(input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic al);
    push_word({exp_seq, 8'hBC}, 2'b01, 2'd2, al);
    push_word(w1, 2'b00, 2'd2, 1'b0);
    push_word(w2, 2'b00, 2'd2, 1'b0);
    push_word(w3, 2'b00, 2'd2, 1'b0);
    exp_frames++;
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    compared++;
    if (TXD !== e.txd || TXK !== e.txk || STATE !== e.state || ALIGN_ERR !== e.align) begin
      mismatched++;
      $display("[TB] FAIL %s word: got txd=%h txk=%b state=%0d align=%b, required txd=%h txk=%b state=%0d align=%b",
               tag, TXD, TXK, STATE, ALIGN_ERR, e.txd, e.txk, e.state, e.align);
    end
  endtask

  task automatic check_value(input string name, input logic [15:0] actual,
                             input logic [15:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check_output();
  endtask

  // One full frame: strobe (or not) with the bus on the frame-start clock,
  // then scramble the bus so the frame must come from the captured copy.
  task automatic apply_stimulus(input logic strobe, input logic [47:0] g, input logic zs);
    BX_STRB = strobe;
    drive_bus(g);
    ZS_EN = zs;
    tick();
    BX_STRB = 1'b0;
    drive_bus(rand_bus());
    tick();
    tick();
    tick();
  endtask

  task automatic run_sync();
    for (int f = 0; f < 16; f++) begin
      push_idle(2'd1);
      apply_stimulus(1'b1, rand_bus(), 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{g:48'hFF00_0000_8001, zs:1'b0, data:1'b1, w1:16'h8001, w2:16'h0000, w3:16'hFF00};
    vecs[1] = '{g:48'h6655_4433_2211, zs:1'b1, data:1'b1, w1:16'h2211, w2:16'h4433, w3:16'h6655};
    vecs[2] = '{g:48'h0000_0000_0000, zs:1'b1, data:1'b0, w1:16'h50BC, w2:16'h50BC, w3:16'h50BC};
    vecs[3] = '{g:48'h0000_0000_0000, zs:1'b0, data:1'b1, w1:16'h0000, w2:16'h0000, w3:16'h0000};
    vecs[4] = '{g:48'h0000_0000_0001, zs:1'b1, data:1'b1, w1:16'h0001, w2:16'h0000, w3:16'h0000};
    vecs[5] = '{g:48'h8000_0000_0000, zs:1'b1, data:1'b1, w1:16'h0000, w2:16'h0000, w3:16'h8000};
    vecs[6] = '{g:48'hFFFF_FFFF_FFFF, zs:1'b0, data:1'b1, w1:16'hFFFF, w2:16'hFFFF, w3:16'hFFFF};
    vecs[7] = '{g:48'hA5C3_3C5A_0FF0, zs:1'b1, data:1'b1, w1:16'h0FF0, w2:16'h3C5A, w3:16'hA5C3};

    RST_B = 1'b0;
    BX_STRB = 1'b0;
    EN = 1'b0;
    ZS_EN = 1'b0;
    LINK_RDY = 1'b0;
    drive_bus(48'd0);
    repeat (2) @(posedge CLK);
    #1;
    check_value("reset_txd", TXD, 16'h50BC);
    check_value("reset_txk", 16'(TXK), 16'h0001);
    check_value("reset_state", 16'(STATE), 16'h0000);
    check_value("reset_align", 16'(ALIGN_ERR), 16'h0000);
    check_value("reset_data_frames", DATA_FRAMES, 16'h0000);
    RST_B = 1'b1;

    // Link down: stays OFF even with EN high.
    tag = "off";
    EN = 1'b1;
    push_idle(2'd0);
    apply_stimulus(1'b1, 48'h1234_5678_9ABC, 1'b0);

    // Link up: sixteen idle SYNC frames, then data.
    tag = "sync";
    LINK_RDY = 1'b1;
    run_sync();

    tag = "table";
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].data) push_data(vecs[i].w1, vecs[i].w2, vecs[i].w3, 1'b0);
      else push_idle(2'd2);
      apply_stimulus(1'b1, vecs[i].g, vecs[i].zs);
      if (vecs[i].data) exp_seq++;
      if (i == 0) check_value("data_frames_first", DATA_FRAMES, 16'd1);
    end
    check_value("data_frames_table", DATA_FRAMES, 16'(exp_frames));

    // Missing strobe: the phase free-runs into the next frame.
    tag = "free_run";
    push_data(16'h0D0C, 16'h0B0A, 16'h0908, 1'b0);
    apply_stimulus(1'b0, 48'h0908_0B0A_0D0C, 1'b0);
    exp_seq++;

    // Zero suppression: three idle frames, SEQ held, then data resumes.
    tag = "zs";
    for (int f = 0; f < 3; f++) begin
      push_idle(2'd2);
      apply_stimulus(1'b1, 48'd0, 1'b1);
    end
    check_value("zs_data_frames_held", DATA_FRAMES, 16'(exp_frames));
    push_data(16'h0000, 16'h0100, 16'h0000, 1'b0);
    apply_stimulus(1'b1, 48'h0000_0100_0000, 1'b1);
    exp_seq++;

    // Early strobe at phase 1 truncates the frame and flags misalignment.
    tag = "align";
    push_word({exp_seq, 8'hBC}, 2'b01, 2'd2, 1'b0);
    push_word(16'hBBAA, 2'b00, 2'd2, 1'b0);
    exp_frames++;
    BX_STRB = 1'b1;
    drive_bus(48'hFFEE_DDCC_BBAA);
    ZS_EN = 1'b0;
    tick();
    BX_STRB = 1'b0;
    drive_bus(rand_bus());
    tick();
    push_data(16'h4444, 16'h5555, 16'h6666, 1'b1);
    apply_stimulus(1'b1, 48'h6666_5555_4444, 1'b0);
    exp_seq++;
    check_value("align_data_frames", DATA_FRAMES, 16'(exp_frames));

    // EN dropped mid-frame: frame completes, OFF at the next frame start.
    tag = "en_off";
    push_data(16'h0102, 16'h0304, 16'h0506, 1'b0);
    BX_STRB = 1'b1;
    drive_bus(48'h0506_0304_0102);
    tick();
    BX_STRB = 1'b0;
    tick();
    EN = 1'b0;
    tick();
    tick();
    exp_seq++;
    push_idle(2'd0);
    apply_stimulus(1'b1, rand_bus(), 1'b0);
    tag = "en_resync";
    EN = 1'b1;
    run_sync();
    exp_seq = 8'd0;
    push_data(vecs[1].w1, vecs[1].w2, vecs[1].w3, 1'b0);
    apply_stimulus(1'b1, vecs[1].g, 1'b0);
    exp_seq++;

    // LINK_RDY dropped while W2 is on the line.
    tag = "link_drop";
    push_word({exp_seq, 8'hBC}, 2'b01, 2'd2, 1'b0);
    push_word(16'h2211, 2'b00, 2'd2, 1'b0);
    push_word(16'h4433, 2'b00, 2'd2, 1'b0);
    exp_frames++;
    BX_STRB = 1'b1;
    drive_bus(48'h6655_4433_2211);
    tick();
    BX_STRB = 1'b0;
    tick();
    tick();
    LINK_RDY = 1'b0;
    push_word(16'h50BC, 2'b01, 2'd0, 1'b0);
    tick();
    tag = "link_resync";
    LINK_RDY = 1'b1;
    run_sync();
    exp_seq = 8'd0;
    push_data(vecs[7].w1, vecs[7].w2, vecs[7].w3, 1'b0);
    apply_stimulus(1'b1, vecs[7].g, 1'b0);
    exp_seq++;

    // 300 back-to-back data frames take SEQ through 255 -> 0.
    tag = "wrap";
    for (int f = 0; f < 300; f++) begin
      gbus = rand_bus();
      push_data(gbus[15:0], gbus[31:16], gbus[47:32], 1'b0);
      apply_stimulus(1'b1, gbus, 1'b0);
      exp_seq++;
    end
    check_value("wrap_data_frames", DATA_FRAMES, 16'(exp_frames));

    // Asynchronous reset between clock edges in the middle of a frame.
    tag = "reset_mid";
    push_word({exp_seq, 8'hBC}, 2'b01, 2'd2, 1'b0);
    push_word(16'h1234, 2'b00, 2'd2, 1'b0);
    BX_STRB = 1'b1;
    drive_bus(48'h0000_0000_1234);
    tick();
    BX_STRB = 1'b0;
    tick();
    #2;
    RST_B = 1'b0;
    #1;
    check_value("reset_mid_txd", TXD, 16'h50BC);
    check_value("reset_mid_txk", 16'(TXK), 16'h0001);
    check_value("reset_mid_state", 16'(STATE), 16'h0000);
    check_value("reset_mid_data_frames", DATA_FRAMES, 16'h0000);
    check_value("reset_mid_queue", 16'(sb.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/comp_frame_tx.md
Name: comp_frame_tx

Overview:
Transmit side of the comparator path. Takes the six 8-bit layer comparator buses after their input buffers (G1C..G6C). Packs one bunch crossing of comparator data into a 4-word, 16-bit 8b/10b-ready frame for the optical link to the trigger motherboard. Provides link sync fill, zero suppression, sequence numbering and frame-alignment monitoring. Sits between the comparator input buffers and the GTX transmitter, clocked at 4x the LCT rate.

Parameters:
SYNC_FRAMES, 16, number of all-idle frames sent after link ready before data frames start (1..255)
IDLE_WORD, 16'h50BC, idle/fill word (K28.5 in low byte, D16.2 in high byte)
ZS_DEFAULT, 1, reset value of zero-suppression enable flag

Ports:
CLK  in  1  transmit clock, 4x LCT clock; single clock domain
RST_B  in  1  asynchronous active-low reset
G1C..G6C  in  8 each  layer comparator bits, already synchronous to CLK
BX_STRB  in  1  one-cycle strobe marking the start of a bunch crossing
EN  in  1  enable data transmission
ZS_EN  in  1  zero-suppression enable; sampled at frame start
LINK_RDY  in  1  GTX transmitter ready
TXD  out  16  transmit word
TXK  out  2  char-is-K flags per byte of TXD
STATE  out  2  0=OFF, 1=SYNC, 2=RUN
ALIGN_ERR  out  1  one-cycle pulse when BX_STRB arrives with phase != 3
DATA_FRAMES  out  16  saturating count of data (non-idle) frames sent

Behaviour:
- Reset (async, RST_B low):
  - TXD=IDLE_WORD, TXK=2'b01, STATE=OFF, phase p=3.
  - Sequence SEQ=0, DATA_FRAMES=0, ALIGN_ERR=0, sync counter 0.
- Phase counter p (0..3):
  - Each clock: if BX_STRB or p==3, then p<=0 (frame start), else p<=p+1.
  - Frame start captures G1C..G6C into a 48-bit hold register and samples ZS_EN.
  - Missing BX_STRB: p free-runs and frames continue back-to-back, with no error.
  - BX_STRB with p in 0..2: current frame is truncated, a new frame starts, ALIGN_ERR pulses high for exactly that clock.
- Output word is registered; index equals p after the update.
  - Latency: data sampled on the frame-start clock appears as W1..W3 on clocks +2..+4; W0 appears on clock +1.
- Data frame:
  - W0 = {SEQ, 8'hBC}, TXK=01.
  - W1 = {G2C, G1C}, TXK=00.
  - W2 = {G4C, G3C}, TXK=00.
  - W3 = {G6C, G5C}, TXK=00.
  - SEQ (8-bit, wraps 255->0) increments at the end of W3.
  - DATA_FRAMES increments on W0 and saturates at 16'hFFFF.
- Idle frame: all four words IDLE_WORD, TXK=01; SEQ unchanged.
- States:
  - OFF: idle frames only. When LINK_RDY && EN, go to SYNC at the next frame start and clear the sync counter.
  - SYNC: send idle frames, counting them. After SYNC_FRAMES frames, go to RUN at the next frame start with SEQ=0.
  - RUN: data frame at each frame start, except when the sampled ZS_EN=1 and all 48 captured bits are 0; then send an idle frame. EN low: go to OFF at the next frame start; the current frame completes.
  - Any state: LINK_RDY low forces OFF immediately. The next clock TXD=IDLE_WORD, the current frame is abandoned and the sync counter is cleared.
- Simultaneous events:
  - Frame start coinciding with LINK_RDY low: LINK_RDY wins.
  - BX_STRB at p==3: normal frame start, no error.
- State transitions occur only at frame start, except the LINK_RDY drop.

Decomposition:
- Shared package comp_link_pkg:
  - State encoding OFF/SYNC/RUN.
  - K28_5 = 8'hBC and IDLE_WORD constant.
  - Frame length = 4.
  - Word-index constants W0..W3.
- One sub-module is natural: comp_frame_mux. Combinational selection of TXD/TXK from p, state, hold register, SEQ and the idle flag; the parent registers its output.
- Phase counter, FSM and counters stay in the top.

Test Plan:
1. Reset, then LINK_RDY=1, EN=1, BX_STRB every 4 clocks, SYNC_FRAMES=16 -> 16 idle frames of 16'h50BC/TXK=01, then STATE=2 and the first data frame W0=16'h00BC.
2. RUN with G1C=8'h01, G2C=8'h80, G6C=8'hFF, others 0, at the strobe -> next 4 clocks TXD = 0x00BC, 0x8001, 0x0000, 0xFF00; TXK = 01, 00, 00, 00; DATA_FRAMES=1.
3. ZS_EN=1, all inputs 0 for 3 frames -> 12 words of 16'h50BC, SEQ unchanged. The next non-zero frame has W0 = {SEQ_prev+1, BC}.
4. BX_STRB asserted at p==1 -> ALIGN_ERR high for one clock, TXD next clock = W0 of the new frame, truncated frame not counted twice.
5. LINK_RDY dropped during W2 of a data frame -> next clock TXD=16'h50BC, STATE=0. On re-assert, a full SYNC_FRAMES idle sequence runs before data.
6. 300 consecutive data frames -> SEQ wraps 255->0. RST_B asserted mid-frame -> TXD=16'h50BC and counters 0 without waiting for a clock edge.
